ddma_mc_tx: RTL and testbench
=============================

DDMA_MC_TX -- requirements
Module: ddma_mc_tx

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent transfer channels (1..8).
REQ-002 SHALL have parameter FLIT_WIDTH, default 16: router flit width in bits.
REQ-003 SHALL have parameter MEMORY_BUS_WIDTH, default 32: memory word width; an integer multiple R = MEMORY_BUS_WIDTH/FLIT_WIDTH of FLIT_WIDTH, with R >= 1.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32: memory word-address width.
REQ-005 clock  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 cmd_in  in  NUM_CH  per-channel start pulse, one cycle.
REQ-008 addr_in  in  NUM_CH x ADDR_WIDTH  per-channel source word address, sampled with cmd_in.
REQ-009 nwords_in  in  NUM_CH x FLIT_WIDTH  per-channel payload length in memory words, sampled with cmd_in.
REQ-010 dest_in  in  NUM_CH x FLIT_WIDTH  per-channel header flit (router target), sampled with cmd_in.
REQ-011 irq_ack_in  in  NUM_CH  per-channel interrupt clear.
REQ-012 status_out  out  NUM_CH  channel busy (pending or transferring).
REQ-013 irq_out  out  NUM_CH  sticky completion interrupt.
REQ-014 mem_enable_o  out  1  memory read strobe.
REQ-015 mem_addr_o  out  ADDR_WIDTH  memory read word address.
REQ-016 mem_data_i  in  MEMORY_BUS_WIDTH  read data, valid exactly one cycle after mem_enable_o.
REQ-017 tx_o  out  1  flit valid towards router.
REQ-018 data_o  out  FLIT_WIDTH  flit data.
REQ-019 credit_i  in  1  router accepts; a flit transfers in any cycle with tx_o=1 and credit_i=1.

Function
REQ-020 cmd_in[c] with status_out[c]=0 SHALL latch addr/nwords/dest for c and set status_out[c] at the next edge; cmd_in[c] while status_out[c]=1 SHALL be ignored.
REQ-021 FSM states IDLE, HDR, SIZE, RD, SER, DONE; IDLE grants one pending channel per packet using round-robin starting at (last granted + 1) mod NUM_CH, channel 0 first after reset.
REQ-022 tx_o SHALL rise two cycles after the accepted cmd_in cycle when the engine was IDLE.
REQ-023 HDR SHALL emit dest flit; SIZE SHALL emit payload flit count nwords*R truncated to FLIT_WIDTH; each advances only on transfer.
REQ-024 while tx_o=1 and credit_i=0, data_o and tx_o SHALL hold stable.
REQ-025 RD SHALL pulse mem_enable_o one cycle at current address; SER SHALL emit the captured word as R flits, least-significant flit first, then address+1 and back to RD, or DONE after the last word; tx_o=0 in RD.
REQ-026 nwords=0 SHALL send HDR and SIZE(0) only, then DONE.
REQ-027 DONE (one cycle) SHALL clear status_out[c], set irq_out[c], return to IDLE.
REQ-028 irq_out[c] SHALL clear on irq_ack_in[c]; if set and ack coincide, irq_out[c] SHALL remain 1.
REQ-029 a channel re-armed by cmd_in in its DONE cycle SHALL be ignored; re-arm accepted from the following cycle.
REQ-030 address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-031 reset=0 at an edge SHALL force IDLE, status_out=0, irq_out=0, tx_o=0, data_o=0, mem_enable_o=0, mem_addr_o=0, round-robin pointer to channel 0, aborting any packet mid-flight without completion interrupt.

Structure
REQ-032 state enum and flit-count/serialisation constants SHALL live in shared package ddma_pkg.
REQ-033 the round-robin arbiter SHALL be a separate sub-module ddma_rr_arbiter (request vector in, one-hot grant plus pointer update on accept).

Verification
REQ-034 ch0 cmd addr=55 nwords=2 dest=0x0011, credit_i=1, R=2 -> flits 0x0011, 0x0004, four payload flits, reads at 55,56, irq_out[0]=1, tx_o first high 2 cycles after cmd.
REQ-035 same, credit_i low 3 cycles during SIZE -> data_o holds 0x0004 those cycles, no flit lost or duplicated.
REQ-036 ch1 and ch3 cmd same cycle -> ch1 packet complete before ch3 header; then ch0 and ch1 pending -> ch3 last granted, so ch0 served before ch1.
REQ-037 ch2 nwords=0 -> exactly two flits, no mem_enable_o, irq_out[2]=1; ack with new completion same cycle -> irq stays 1.
REQ-038 reset=0 mid-payload -> next cycle all outputs zero, irq_out=0; new cmd afterwards completes normally.

Source files
------------

// File: rtl/ddma_pkg.sv
// ddma_pkg: shared engine states and flit/serialisation helpers
package ddma_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SIZE, S_RD, S_SER, S_DONE} state_t;
  function automatic int flits_per_word(input int mem_w, input int flit_w);
    return mem_w / flit_w;
  endfunction
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ddma_rr_arbiter.sv
// ddma_rr_arbiter: round-robin one-hot grant, pointer advances past the winner on accept
module ddma_rr_arbiter
  import ddma_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic         accept_i,
  output logic [N-1:0] gnt_o
);
  localparam int PW = idx_width(N);
  logic [PW-1:0] ptr_q, ptr_d;
  // scan from the pointer; iterating backwards leaves the nearest requester as winner
  always_comb begin
    int j;
    int nxt;
    gnt_o = '0;
    nxt = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr_q) + i) % N;
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        nxt = (j + 1) % N;
      end
    end
    ptr_d = (accept_i && |req_i) ? PW'(nxt) : ptr_q;
  end
  // pointer register, channel 0 first after reset
  always_ff @(posedge clock) begin
    if (!reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/ddma_mc_tx.sv
// ddma_mc_tx: multi-channel DMA engine packetising memory words into router flits
module ddma_mc_tx
  import ddma_pkg::*;
#(
  parameter int NUM_CH           = 4,
  parameter int FLIT_WIDTH       = 16,
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_CH-1:0]                    cmd_in,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    addr_in,
  input  logic [NUM_CH-1:0][FLIT_WIDTH-1:0]    nwords_in,
  input  logic [NUM_CH-1:0][FLIT_WIDTH-1:0]    dest_in,
  input  logic [NUM_CH-1:0]                    irq_ack_in,
  output logic [NUM_CH-1:0]                    status_out,
  output logic [NUM_CH-1:0]                    irq_out,
  output logic                                 mem_enable_o,
  output logic [ADDR_WIDTH-1:0]                mem_addr_o,
  input  logic [MEMORY_BUS_WIDTH-1:0]          mem_data_i,
  output logic                                 tx_o,
  output logic [FLIT_WIDTH-1:0]                data_o,
  input  logic                                 credit_i
);
  localparam int R  = flits_per_word(MEMORY_BUS_WIDTH, FLIT_WIDTH);
  localparam int CW = idx_width(NUM_CH);
  localparam int RW = idx_width(R);

  state_t                                state_q, state_d;
  logic [CW-1:0]                         cur_q, cur_d;
  logic [NUM_CH-1:0]                     status_q, status_d, irq_q, irq_d;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]     ca_q, ca_d;
  logic [NUM_CH-1:0][FLIT_WIDTH-1:0]     cn_q, cn_d, cd_q, cd_d;
  logic [ADDR_WIDTH-1:0]                 addr_q, addr_d;
  logic [FLIT_WIDTH-1:0]                 cnt_q, cnt_d;
  logic [RW-1:0]                         fidx_q, fidx_d;
  logic                                  cap_q, cap_d;
  logic [MEMORY_BUS_WIDTH-1:0]           word_q, word_d, word_cur;
  logic [NUM_CH-1:0]                     gnt;
  logic [CW-1:0]                         gnt_idx;
  logic                                  accept;

  assign status_out = status_q;
  assign irq_out    = irq_q;
  assign accept     = (state_q == S_IDLE) && |status_q;
  assign word_cur   = cap_q ? mem_data_i : word_q;

  ddma_rr_arbiter #(.N(NUM_CH)) u_arb (
    .clock    (clock),
    .reset    (reset),
    .req_i    (status_q),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  // one-hot grant to channel index
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++) if (gnt[i]) gnt_idx = CW'(i);
  end

  // per-channel command latch, busy flags and sticky interrupts (a new completion beats an ack)
  always_comb begin
    status_d = status_q;
    irq_d    = irq_q & ~irq_ack_in;
    ca_d     = ca_q;
    cn_d     = cn_q;
    cd_d     = cd_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cmd_in[c] && !status_q[c]) begin
        status_d[c] = 1'b1;
        ca_d[c]     = addr_in[c];
        cn_d[c]     = nwords_in[c];
        cd_d[c]     = dest_in[c];
      end
    end
    if (state_q == S_DONE) begin
      status_d[cur_q] = 1'b0;
      irq_d[cur_q]    = 1'b1;
    end
  end

  // packet engine: header, size, then read/serialise each word; the first SER cycle forwards mem_data_i directly
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    fidx_d       = fidx_q;
    cap_d        = 1'b0;
    word_d       = word_cur;
    tx_o         = 1'b0;
    data_o       = '0;
    mem_enable_o = 1'b0;
    mem_addr_o   = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_HDR;
          cur_d   = gnt_idx;
          addr_d  = ca_q[gnt_idx];
          cnt_d   = cn_q[gnt_idx];
          fidx_d  = '0;
        end
      end
      S_HDR: begin
        tx_o   = 1'b1;
        data_o = cd_q[cur_q];
        if (credit_i) state_d = S_SIZE;
      end
      S_SIZE: begin
        tx_o   = 1'b1;
        data_o = cnt_q * FLIT_WIDTH'(R);
        if (credit_i) state_d = (cnt_q == '0) ? S_DONE : S_RD;
      end
      S_RD: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = addr_q;
        cap_d        = 1'b1;
        state_d      = S_SER;
      end
      S_SER: begin
        tx_o   = 1'b1;
        data_o = word_cur[fidx_q*FLIT_WIDTH +: FLIT_WIDTH];
        if (credit_i) begin
          if (fidx_q == RW'(R - 1)) begin
            fidx_d  = '0;
            cnt_d   = cnt_q - FLIT_WIDTH'(1);
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = (cnt_q == FLIT_WIDTH'(1)) ? S_DONE : S_RD;
          end else begin
            fidx_d = fidx_q + RW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state registers, synchronous active-low reset aborts any packet in flight
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      status_q <= '0;
      irq_q    <= '0;
      ca_q     <= '0;
      cn_q     <= '0;
      cd_q     <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      fidx_q   <= '0;
      cap_q    <= 1'b0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      status_q <= status_d;
      irq_q    <= irq_d;
      ca_q     <= ca_d;
      cn_q     <= cn_d;
      cd_q     <= cd_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      fidx_q   <= fidx_d;
      cap_q    <= cap_d;
      word_q   <= word_d;
    end
  end
endmodule

// File: tb/tb_ddma_mc_tx.sv
// tb_ddma_mc_tx: scenario tasks plus randomized traffic checked against a packet-level model
module tb_ddma_mc_tx;
  localparam int N = 4, FW = 16, MW = 32, AW = 32, R = MW / FW;

  logic clock = 1'b0, reset = 1'b0;
  logic [N-1:0] cmd_in = '0, irq_ack_in = '0, status_out, irq_out;
  logic [N-1:0][AW-1:0] addr_in = '0;
  logic [N-1:0][FW-1:0] nwords_in = '0, dest_in = '0;
  logic mem_enable_o, tx_o, credit_i = 1'b1;
  logic [AW-1:0] mem_addr_o;
  logic [MW-1:0] mem_data_i = '0;
  logic [FW-1:0] data_o;

  int vecs = 0, errs = 0, rr_ptr = 0;
  logic [FW-1:0] fq[$], ef[$];
  logic [AW-1:0] rq[$], er[$];
  logic [AW-1:0] ca[N];
  logic [FW-1:0] cn[N], cd[N];

  typedef struct {logic [AW-1:0] a; logic [FW-1:0] n; logic [FW-1:0] d;} cmd_t;
  cmd_t pend[N][$];

  always #5 clock = ~clock;

  ddma_mc_tx #(.NUM_CH(N), .FLIT_WIDTH(FW), .MEMORY_BUS_WIDTH(MW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .cmd_in(cmd_in), .addr_in(addr_in), .nwords_in(nwords_in),
    .dest_in(dest_in), .irq_ack_in(irq_ack_in), .status_out(status_out), .irq_out(irq_out),
    .mem_enable_o(mem_enable_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .tx_o(tx_o), .data_o(data_o), .credit_i(credit_i)
  );

  function automatic logic [MW-1:0] mem_word(logic [AW-1:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16] + a[15:0] + 16'h1234};
  endfunction

  // memory answers one cycle after the strobe; garbage otherwise
  always @(posedge clock) mem_data_i <= mem_enable_o ? mem_word(mem_addr_o) : MW'($urandom);

  // record every transferred flit and every memory read
  always @(negedge clock) begin
    if (reset) begin
      if (tx_o && credit_i) fq.push_back(data_o);
      if (mem_enable_o) rq.push_back(mem_addr_o);
    end
  end

  function automatic void expect_pkt(int c);
    logic [MW-1:0] w;
    ef.push_back(cd[c]);
    ef.push_back(FW'(cn[c] * R));
    for (int k = 0; k < int'(cn[c]); k++) begin
      w = mem_word(ca[c] + AW'(k));
      er.push_back(ca[c] + AW'(k));
      for (int j = 0; j < R; j++) ef.push_back(w[j*FW +: FW]);
    end
  endfunction

  function automatic void rr_expect(logic [N-1:0] set);
    int last = -1;
    for (int i = 0; i < N; i++) begin
      int j = (rr_ptr + i) % N;
      if (set[j]) begin
        expect_pkt(j);
        last = j;
      end
    end
    if (last >= 0) rr_ptr = (last + 1) % N;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_q();
    fq.delete(); rq.delete(); ef.delete(); er.delete();
  endtask

  task automatic set_ch(int c, logic [AW-1:0] a, logic [FW-1:0] n, logic [FW-1:0] d);
    ca[c] = a; cn[c] = n; cd[c] = d;
    addr_in[c] = a; nwords_in[c] = n; dest_in[c] = d;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (status_out == '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    vecs++;
    if ({status_out, irq_out, tx_o, data_o, mem_enable_o, mem_addr_o} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got st=%h irq=%h tx=%b d=%h en=%b a=%h want all 0",
               status_out, irq_out, tx_o, data_o, mem_enable_o, mem_addr_o);
    end
    reset = 1'b1;
    rr_ptr = 0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    clear_q();
    set_ch(0, 55, 2, 16'h0011);
    rr_expect(4'b0001);
    cmd_in = 4'b0001;
    @(negedge clock);
    vecs++;
    if (tx_o !== 1'b0) begin errs++; $display("FAIL basic_tx_cmd_cycle got %b want 0", tx_o); end
    @(posedge clock); #1;
    cmd_in = '0;
    @(negedge clock);
    vecs++;
    if (tx_o !== 1'b0) begin errs++; $display("FAIL basic_tx_plus1 got %b want 0", tx_o); end
    @(negedge clock);
    vecs++;
    if ({tx_o, data_o} !== {1'b1, 16'h0011}) begin
      errs++; $display("FAIL basic_tx_plus2 got %b/%h want 1/0011", tx_o, data_o);
    end
    @(posedge clock); #1;
    wait_idle(ok);
    vecs++;
    if (!ok) begin errs++; $display("FAIL basic_timeout got busy %h want 0", status_out); end
    vecs++;
    if (fq.size() != ef.size() || rq.size() != er.size()) begin
      errs++; $display("FAIL basic_len got %0d/%0d want %0d/%0d", fq.size(), rq.size(), ef.size(), er.size());
    end
    for (int i = 0; i < fq.size() && i < ef.size(); i++) begin
      vecs++;
      if (fq[i] !== ef[i]) begin errs++; $display("FAIL basic_flit%0d got %h want %h", i, fq[i], ef[i]); end
    end
    for (int i = 0; i < rq.size() && i < er.size(); i++) begin
      vecs++;
      if (rq[i] !== er[i]) begin errs++; $display("FAIL basic_read%0d got %h want %h", i, rq[i], er[i]); end
    end
    vecs++;
    if (irq_out !== 4'b0001) begin errs++; $display("FAIL basic_irq got %b want 0001", irq_out); end
    irq_ack_in = 4'b0001;
    tick();
    irq_ack_in = '0;
    vecs++;
    if (irq_out !== 4'b0000) begin errs++; $display("FAIL basic_ack got %b want 0000", irq_out); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_q();
    set_ch(0, 55, 2, 16'h0011);
    rr_expect(4'b0001);
    cmd_in = 4'b0001;
    tick();
    cmd_in = '0;
    tick();
    tick();
    credit_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vecs++;
      if ({tx_o, data_o} !== {1'b1, 16'h0004}) begin
        errs++; $display("FAIL bp_hold%0d got %b/%h want 1/0004", i, tx_o, data_o);
      end
      tick();
    end
    credit_i = 1'b1;
    wait_idle(ok);
    vecs++;
    if (!ok) begin errs++; $display("FAIL bp_timeout got busy %h want 0", status_out); end
    vecs++;
    if (fq.size() != ef.size() || rq.size() != er.size()) begin
      errs++; $display("FAIL bp_len got %0d/%0d want %0d/%0d", fq.size(), rq.size(), ef.size(), er.size());
    end
    for (int i = 0; i < fq.size() && i < ef.size(); i++) begin
      vecs++;
      if (fq[i] !== ef[i]) begin errs++; $display("FAIL bp_flit%0d got %h want %h", i, fq[i], ef[i]); end
    end
    irq_ack_in = '1;
    tick();
    irq_ack_in = '0;
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [N-1:0] sets[3] = '{4'b1010, 4'b0011, 4'b1001};
    for (int r = 0; r < 3; r++) begin
      clear_q();
      for (int c = 0; c < N; c++)
        if (sets[r][c]) set_ch(c, $urandom, FW'($urandom_range(1, 3)), FW'($urandom));
      rr_expect(sets[r]);
      cmd_in = sets[r];
      tick();
      cmd_in = '0;
      wait_idle(ok);
      vecs++;
      if (!ok) begin errs++; $display("FAIL rr%0d_timeout got busy %h want 0", r, status_out); end
      vecs++;
      if (fq.size() != ef.size() || rq.size() != er.size()) begin
        errs++; $display("FAIL rr%0d_len got %0d/%0d want %0d/%0d", r, fq.size(), rq.size(), ef.size(), er.size());
      end
      for (int i = 0; i < fq.size() && i < ef.size(); i++) begin
        vecs++;
        if (fq[i] !== ef[i]) begin errs++; $display("FAIL rr%0d_flit%0d got %h want %h", r, i, fq[i], ef[i]); end
      end
      for (int i = 0; i < rq.size() && i < er.size(); i++) begin
        vecs++;
        if (rq[i] !== er[i]) begin errs++; $display("FAIL rr%0d_read%0d got %h want %h", r, i, rq[i], er[i]); end
      end
      vecs++;
      if (irq_out !== sets[r]) begin errs++; $display("FAIL rr%0d_irq got %b want %b", r, irq_out, sets[r]); end
      irq_ack_in = '1;
      tick();
      irq_ack_in = '0;
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    clear_q();
    set_ch(2, $urandom, 0, 16'hbeef);
    rr_expect(4'b0100);
    cmd_in = 4'b0100;
    tick();
    cmd_in = '0;
    wait_idle(ok);
    vecs++;
    if (!ok) begin errs++; $display("FAIL zero_timeout got busy %h want 0", status_out); end
    vecs++;
    if (fq.size() != 2 || rq.size() != 0) begin
      errs++; $display("FAIL zero_len got %0d flits %0d reads want 2 flits 0 reads", fq.size(), rq.size());
    end
    for (int i = 0; i < fq.size() && i < ef.size(); i++) begin
      vecs++;
      if (fq[i] !== ef[i]) begin errs++; $display("FAIL zero_flit%0d got %h want %h", i, fq[i], ef[i]); end
    end
    vecs++;
    if (irq_out[2] !== 1'b1) begin errs++; $display("FAIL zero_irq got %b want 1", irq_out[2]); end
    // second packet: ack and a re-arm land in its completion cycle
    cmd_in = 4'b0100;
    tick();
    cmd_in = '0;
    repeat (3) tick();
    irq_ack_in = 4'b0100;
    cmd_in = 4'b0100;
    tick();
    irq_ack_in = '0;
    cmd_in = '0;
    vecs++;
    if (irq_out[2] !== 1'b1) begin errs++; $display("FAIL zero_ack_collide got %b want 1", irq_out[2]); end
    vecs++;
    if (status_out[2] !== 1'b0) begin errs++; $display("FAIL zero_done_rearm got %b want 0", status_out[2]); end
    tick();
    vecs++;
    if (status_out[2] !== 1'b0) begin errs++; $display("FAIL zero_rearm_ignored got %b want 0", status_out[2]); end
    irq_ack_in = 4'b0100;
    tick();
    irq_ack_in = '0;
    vecs++;
    if (irq_out[2] !== 1'b0) begin errs++; $display("FAIL zero_ack got %b want 0", irq_out[2]); end
    // third packet: re-arm after the completion cycle is accepted
    clear_q();
    rr_expect(4'b0100);
    cmd_in = 4'b0100;
    tick();
    cmd_in = '0;
    vecs++;
    if (status_out[2] !== 1'b1) begin errs++; $display("FAIL zero_rearm_accept got %b want 1", status_out[2]); end
    wait_idle(ok);
    vecs++;
    if (fq.size() != ef.size() || !ok) begin
      errs++; $display("FAIL zero_third got %0d flits want %0d", fq.size(), ef.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_q();
    set_ch(0, $urandom, 8, 16'h1234);
    cmd_in = 4'b0001;
    tick();
    cmd_in = '0;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    vecs++;
    if ({status_out, irq_out, tx_o, data_o, mem_enable_o, mem_addr_o} !== '0) begin
      errs++;
      $display("FAIL midreset_outputs got st=%h irq=%h tx=%b d=%h en=%b a=%h want all 0",
               status_out, irq_out, tx_o, data_o, mem_enable_o, mem_addr_o);
    end
    reset = 1'b1;
    rr_ptr = 0;
    tick();
    clear_q();
    set_ch(1, $urandom, 3, 16'h4321);
    rr_expect(4'b0010);
    cmd_in = 4'b0010;
    tick();
    cmd_in = '0;
    wait_idle(ok);
    vecs++;
    if (!ok || irq_out !== 4'b0010) begin
      errs++; $display("FAIL midreset_after got irq %b want 0010", irq_out);
    end
    vecs++;
    if (fq.size() != ef.size() || rq.size() != er.size()) begin
      errs++; $display("FAIL midreset_len got %0d/%0d want %0d/%0d", fq.size(), rq.size(), ef.size(), er.size());
    end
    for (int i = 0; i < fq.size() && i < ef.size(); i++) begin
      vecs++;
      if (fq[i] !== ef[i]) begin errs++; $display("FAIL midreset_flit%0d got %h want %h", i, fq[i], ef[i]); end
    end
    irq_ack_in = '1;
    tick();
    irq_ack_in = '0;
  endtask

  task automatic test_random();
    bit busy[N];
    int freec[N];
    cmd_t e;
    int c, sz;
    clear_q();
    for (int k = 0; k < N; k++) begin
      busy[k] = 1'b0;
      freec[k] = 2;
      pend[k].delete();
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      credit_i = ($urandom_range(0, 3) != 0);
      irq_ack_in = irq_out & N'($urandom);
      cmd_in = '0;
      for (int k = 0; k < N; k++) if (!busy[k]) freec[k]++;
      while (fq.size() >= 2 && fq.size() >= 2 + int'(fq[1])) begin
        c = int'(fq[0][15:12]);
        sz = int'(fq[1]);
        vecs++;
        if (c >= N || pend[c].size() == 0) begin
          errs++; $display("FAIL rand_header got %h want a pending channel tag", fq[0]);
          fq.delete(); rq.delete();
          break;
        end
        e = pend[c].pop_front();
        vecs++;
        if (fq[0] !== e.d || fq[1] !== FW'(e.n * R)) begin
          errs++; $display("FAIL rand_hdr_size ch%0d got %h/%h want %h/%h", c, fq[0], fq[1], e.d, FW'(e.n * R));
        end else begin
          for (int k = 0; k < int'(e.n); k++) begin
            vecs++;
            if (rq.size() == 0 || rq[0] !== e.a + AW'(k)) begin
              errs++; $display("FAIL rand_read ch%0d got %h want %h", c, rq.size() ? rq[0] : 'x, e.a + AW'(k));
            end
            if (rq.size()) void'(rq.pop_front());
            for (int j = 0; j < R; j++) begin
              logic [MW-1:0] w = mem_word(e.a + AW'(k));
              vecs++;
              if (fq[2 + k*R + j] !== w[j*FW +: FW]) begin
                errs++; $display("FAIL rand_flit ch%0d w%0d f%0d got %h want %h", c, k, j, fq[2 + k*R + j], w[j*FW +: FW]);
              end
            end
          end
        end
        repeat (2 + sz) void'(fq.pop_front());
        busy[c] = 1'b0;
        freec[c] = 0;
      end
      if (cyc < 2500) begin
        for (int k = 0; k < N; k++) begin
          if (!busy[k] && freec[k] >= 2 && $urandom_range(0, 5) == 0) begin
            e.a = ($urandom_range(0, 3) == 0) ? 32'hffff_fffe : AW'($urandom);
            e.n = FW'($urandom_range(0, 4));
            e.d = {4'(k), 12'($urandom)};
            addr_in[k] = e.a; nwords_in[k] = e.n; dest_in[k] = e.d;
            cmd_in[k] = 1'b1;
            pend[k].push_back(e);
            busy[k] = 1'b1;
          end else if (busy[k] && $urandom_range(0, 7) == 0) begin
            addr_in[k] = AW'($urandom); nwords_in[k] = FW'($urandom); dest_in[k] = FW'($urandom);
            cmd_in[k] = 1'b1;
          end
        end
      end else if (!(busy[0] || busy[1] || busy[2] || busy[3])) begin
        break;
      end
      tick();
    end
    cmd_in = '0;
    credit_i = 1'b1;
    vecs++;
    if (busy[0] || busy[1] || busy[2] || busy[3] || fq.size() != 0 || rq.size() != 0) begin
      errs++; $display("FAIL rand_drain got busy %b%b%b%b leftover %0d/%0d want none",
                       busy[3], busy[2], busy[1], busy[0], fq.size(), rq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_round_robin();
    test_zero_len();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
